// File: rtl/bp_be_late_wb_arbiter.sv
// ---------------------------------------------------------------------------
// bp_be_late_wb_arbiter
//
// Shares the single late writeback port of the integer and FP register
// files among the long-latency producers. Source 0 is the integer divider,
// source 1 is FP div/sqrt, source 2 is the D$ load-miss fill and source 3 is
// the accelerator. Each producer owns a one-entry holding slot. A
// round-robin arbiter picks one request per cycle and presents it as the
// late writeback packet. That packet also clears the matching scoreboard
// bit in the hazard detector.
//
// Optional feature, selected at compile time:
//   BP_BE_LATE_WB_BYPASS_EN  defined   : an incoming request takes part in
//                                         arbitration in the cycle it
//                                         arrives, so an empty granted slot
//                                         is bypassed (0-cycle latency).
//   BP_BE_LATE_WB_BYPASS_EN  undefined : every request is registered first
//                                         (1-cycle latency). No
//                                         combinational path runs from any
//                                         src_*_i to any wb_*_o.
//
// Ports:
//   clk_i            clock, rising edge
//   reset_i          asynchronous active-high reset
//   src_v_i          per-source writeback request valid
//   src_ready_and_o  per-source accept (transfer = src_v_i & src_ready_and_o)
//   src_fp_i         per-source target file (1 = FP, 0 = integer)
//   src_rd_addr_i    per-source destination register, packed by source
//   src_data_i       per-source result data, packed by source
//   src_fflags_i     per-source accrued FP flags, packed by source
//   wb_v_o           late writeback valid
//   wb_ready_and_i   register file accepts the late write this cycle
//   wb_fp_o          target file of the presented entry
//   wb_rd_addr_o     destination register of the presented entry
//   wb_data_o        data of the presented entry
//   wb_fflags_o      flags of the presented entry (0 for integer targets)
//   wb_src_o         index of the granted source
//   pending_o        per-source slot occupancy
// ---------------------------------------------------------------------------
module bp_be_late_wb_arbiter #(
  parameter int num_src_p        = 4,
  parameter int reg_addr_width_p = 5,
  parameter int data_width_p     = 64
) (
  input  logic                                 clk_i,
  input  logic                                 reset_i,

  input  logic [num_src_p-1:0]                 src_v_i,
  output logic [num_src_p-1:0]                 src_ready_and_o,
  input  logic [num_src_p-1:0]                 src_fp_i,
  input  logic [num_src_p*reg_addr_width_p-1:0] src_rd_addr_i,
  input  logic [num_src_p*data_width_p-1:0]    src_data_i,
  input  logic [num_src_p*5-1:0]               src_fflags_i,

  output logic                                 wb_v_o,
  input  logic                                 wb_ready_and_i,
  output logic                                 wb_fp_o,
  output logic [reg_addr_width_p-1:0]          wb_rd_addr_o,
  output logic [data_width_p-1:0]              wb_data_o,
  output logic [4:0]                           wb_fflags_o,
  output logic [$clog2(num_src_p)-1:0]         wb_src_o,
  output logic [num_src_p-1:0]                 pending_o
);

  localparam int idx_w_lp = $clog2(num_src_p);

  // Per-source holding slots
  logic [num_src_p-1:0]        r_full;
  logic [num_src_p-1:0]        r_fp;
  logic [reg_addr_width_p-1:0] r_rd     [num_src_p];
  logic [data_width_p-1:0]     r_data   [num_src_p];
  logic [4:0]                  r_fflags [num_src_p];

  // Round-robin pointer: index of the last source that retired
  logic [idx_w_lp-1:0]         r_last;

  // A presented entry that was not accepted is pinned until it is, so a
  // newly arriving higher-priority request cannot replace it mid-stall.
  logic                        r_hold;
  logic [idx_w_lp-1:0]         r_hold_idx;

  logic [num_src_p-1:0]        w_req;
  logic [num_src_p-1:0]        w_grant;
  logic [idx_w_lp-1:0]         w_gnt_idx;
  logic [idx_w_lp-1:0]         w_scan;
  logic                        w_found;
  logic                        w_fire;
  logic [num_src_p-1:0]        w_accept;
  logic [num_src_p-1:0]        w_drain;
  logic [num_src_p-1:0]        w_direct;
  logic [num_src_p-1:0]        w_load;

  logic                        w_sel_fp;
  logic [reg_addr_width_p-1:0] w_sel_rd;
  logic [data_width_p-1:0]     w_sel_data;
  logic [4:0]                  w_sel_fflags;

  // -------------------------------------------------------------------------
  // Request vector
  // -------------------------------------------------------------------------
`ifdef BP_BE_LATE_WB_BYPASS_EN
  // Incoming requests are masked during reset so wb_v_o stays low even if a
  // producer is still driving valid.
  assign w_req = r_full | (src_v_i & {num_src_p{~reset_i}});
`else
  assign w_req = r_full;
`endif

  // -------------------------------------------------------------------------
  // Round-robin grant: first request above r_last, wrapping around.
  // -------------------------------------------------------------------------
  always_comb begin
    w_grant   = '0;
    w_gnt_idx = '0;
    w_scan    = '0;
    w_found   = 1'b0;
    if (r_hold) begin
      w_grant[r_hold_idx] = 1'b1;
      w_gnt_idx           = r_hold_idx;
    end else begin
      for (int k = 1; k <= num_src_p; k++) begin
        w_scan = idx_w_lp'((int'(r_last) + k) % num_src_p);
        if (!w_found && w_req[w_scan]) begin
          w_found          = 1'b1;
          w_grant[w_scan]  = 1'b1;
          w_gnt_idx        = w_scan;
        end
      end
    end
  end

  assign wb_v_o   = |w_req;
  assign w_fire   = wb_v_o & wb_ready_and_i;
  assign wb_src_o = w_gnt_idx;

  // -------------------------------------------------------------------------
  // Output mux over the one-hot grant; all zeros when nothing is granted.
  // -------------------------------------------------------------------------
  always_comb begin
    w_sel_fp     = 1'b0;
    w_sel_rd     = '0;
    w_sel_data   = '0;
    w_sel_fflags = '0;
    for (int i = 0; i < num_src_p; i++) begin
      if (w_grant[i]) begin
`ifdef BP_BE_LATE_WB_BYPASS_EN
        if (!r_full[i]) begin
          w_sel_fp     = src_fp_i[i];
          w_sel_rd     = src_rd_addr_i[i*reg_addr_width_p +: reg_addr_width_p];
          w_sel_data   = src_data_i[i*data_width_p +: data_width_p];
          w_sel_fflags = src_fflags_i[i*5 +: 5];
        end else begin
          w_sel_fp     = r_fp[i];
          w_sel_rd     = r_rd[i];
          w_sel_data   = r_data[i];
          w_sel_fflags = r_fflags[i];
        end
`else
        w_sel_fp     = r_fp[i];
        w_sel_rd     = r_rd[i];
        w_sel_data   = r_data[i];
        w_sel_fflags = r_fflags[i];
`endif
      end
    end
  end

  assign wb_fp_o      = w_sel_fp;
  assign wb_rd_addr_o = w_sel_rd;
  assign wb_data_o    = w_sel_data;
  // Integer writebacks never carry FP exception flags.
  assign wb_fflags_o  = w_sel_fp ? w_sel_fflags : 5'b0;

  // -------------------------------------------------------------------------
  // Handshakes and slot control
  // -------------------------------------------------------------------------
  // A full slot can still accept when it is being drained this cycle, which
  // keeps a continuously granted source at one writeback per cycle.
  assign src_ready_and_o = ~r_full | (w_grant & {num_src_p{wb_ready_and_i}});
  assign w_accept        = src_v_i & src_ready_and_o;
  assign w_drain         = w_grant & {num_src_p{w_fire}};

`ifdef BP_BE_LATE_WB_BYPASS_EN
  // An input that goes straight out through the bypass is never stored.
  assign w_direct = w_accept & w_grant & ~r_full & {num_src_p{wb_ready_and_i}};
`else
  assign w_direct = '0;
`endif

  assign w_load    = w_accept & ~w_direct;
  assign pending_o = r_full;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_full     <= '0;
      r_fp       <= '0;
      r_last     <= idx_w_lp'(num_src_p - 1);
      r_hold     <= 1'b0;
      r_hold_idx <= '0;
      for (int i = 0; i < num_src_p; i++) begin
        r_rd[i]     <= '0;
        r_data[i]   <= '0;
        r_fflags[i] <= '0;
      end
    end else begin
      for (int i = 0; i < num_src_p; i++) begin
        if (w_load[i]) begin
          r_full[i]   <= 1'b1;
          r_fp[i]     <= src_fp_i[i];
          r_rd[i]     <= src_rd_addr_i[i*reg_addr_width_p +: reg_addr_width_p];
          r_data[i]   <= src_data_i[i*data_width_p +: data_width_p];
          r_fflags[i] <= src_fflags_i[i*5 +: 5];
        end else if (w_drain[i]) begin
          r_full[i]   <= 1'b0;
        end
      end
      if (w_fire) begin
        r_last <= w_gnt_idx;
      end
      r_hold     <= wb_v_o & ~wb_ready_and_i;
      r_hold_idx <= w_gnt_idx;
    end
  end

endmodule

// File: doc/bp_be_late_wb_arbiter.md
# bp_be_late_wb_arbiter

Round-robin arbiter and skid buffer that shares the single late writeback port of the integer and FP register files among the long-latency producers: integer divider, FP divider/sqrt, D$ load-miss fill and accelerator. Each producer gets a one-entry holding slot. The selected entry is presented as the late writeback packet, which also clears the corresponding scoreboard bit in the hazard detector. A per-source occupancy vector is exported so that issue logic can stall structurally on a full slot.

## Interface
Parameters:
- num_src_p, 4, number of late producers (2..8); index 0 = idiv, 1 = fdiv, 2 = load miss, 3 = accel
- reg_addr_width_p, 5, register address width
- data_width_p, 64, writeback data width

Ports:
- clk_i  in  1  clock; all state updates on posedge
- reset_i  in  1  reset, asynchronous, active-high
- src_v_i  in  num_src_p  per-source writeback request valid
- src_ready_and_o  out  num_src_p  per-source accept; a transfer occurs on src_v_i & src_ready_and_o
- src_fp_i  in  num_src_p  1 = FP register file target, 0 = integer
- src_rd_addr_i  in  num_src_p*reg_addr_width_p  destination register, packed by source
- src_data_i  in  num_src_p*data_width_p  result data
- src_fflags_i  in  num_src_p*5  accrued FP exception flags (ignored if src_fp_i=0)
- wb_v_o  out  1  late writeback valid
- wb_ready_and_i  in  1  register file accepts the late write this cycle
- wb_fp_o  out  1  target file of the presented entry
- wb_rd_addr_o  out  reg_addr_width_p  destination register
- wb_data_o  out  data_width_p  data
- wb_fflags_o  out  5  flags; forced to 0 when wb_fp_o=0
- wb_src_o  out  log2(num_src_p)  index of the granted source
- pending_o  out  num_src_p  slot occupancy (full_r)

## Operation
- State: per-source full_r, fp_r, rd_r, data_r, fflags_r; round-robin pointer last_r (index of the last granted source).
- Request vector req = full_r, plus src_v_i when bypass is compiled in (see Configuration).
- Grant: the first set bit of req searching from last_r+1 upward, with wrap-around modulo num_src_p. At most one grant per cycle. wb_v_o = |req.
- Output mux: the granted slot's registers. With bypass, the incoming fields are used when the granted source's slot is empty.
- last_r updates to the granted index only on wb_v_o & wb_ready_and_i. A stalled grant keeps the pointer, and the presented entry stays stable until accepted.
- src_ready_and_o[i] = ~full_r[i] | (grant[i] & wb_ready_and_i). This allows one writeback per cycle from the same source while it is continuously granted.
- Slot update per source, in priority order:
  - accept and not drained: load and set full.
  - drained and no accept: clear full.
  - drained and accept in the same cycle: reload and stay full.
  - With bypass, an accepted input that is itself granted and accepted is not stored.
- Two sources targeting the same rd is legal. They retire in grant order, and the arbiter performs no merging.
- wb_fflags_o = fp ? fflags : 0.

## Timing
- Reset values: full_r=0, last_r=num_src_p-1 (source 0 highest first), data, rd and flags registers = 0.
- Outputs during and after reset: wb_v_o=0, src_ready_and_o=all 1s, pending_o=0, wb_src_o=0, wb_rd_addr_o=0, wb_data_o=0.
- Reset asserted mid-operation drops all buffered entries immediately (asynchronous). Producers must be reset together.
- Latency from accept to wb_v_o is 1 cycle without bypass and 0 cycles with bypass.
- Throughput is one writeback per cycle when wb_ready_and_i is held high.
- Worst-case wait for a full slot with wb_ready_and_i=1 is num_src_p-1 cycles.
- wb_v_o is never retracted or altered while wb_ready_and_i=0.
- The request path is combinational only through wb_ready_and_i to src_ready_and_o.

## Configuration
- BP_BE_LATE_WB_BYPASS_EN defined: incoming requests participate in arbitration in the cycle they arrive, giving 0-cycle latency when the granted slot is empty.
- BP_BE_LATE_WB_BYPASS_EN undefined: every request is registered first, giving 1-cycle latency. There is no combinational path from any src_*_i to any wb_*_o.
- Both builds must pass the same test plan, with latencies adjusted accordingly.

## Test plan
- Single request, no bypass: src 2 pulses v with rd=7, data=0x1234, fp=0, and wb_ready_and_i=1. Required: wb_v_o in the next cycle with rd=7, data=0x1234, wb_src_o=2, wb_fflags_o=0; pending_o returns to 0 one cycle later.
- Round-robin fairness: all 4 sources hold v=1 and ready=1 from reset. Required: grant order 0,1,2,3,0,1…, one writeback per cycle after the first.
- Backpressure: src 1 buffered with wb_ready_and_i=0 for 5 cycles. Required: wb_v_o=1 with identical fields all 5 cycles, src_ready_and_o[1]=0, last_r unchanged; drains on the cycle ready rises.
- Simultaneous drain and refill: src 0 full and granted with ready=1 while new data 0xBEEF arrives. Required: the old entry is written and the slot reloads with 0xBEEF with no bubble.
- FP flags: src 1 with fp=1, rd=3, fflags=5'b00101. Required: wb_fp_o=1, wb_fflags_o=5'b00101. The same request with fp=0 gives wb_fflags_o=0.
- Asynchronous reset with 3 slots full: assert reset_i between clock edges. Required: pending_o=0 and wb_v_o=0 immediately; after release the first grant goes to source 0.
